// File: rtl/gf_inv_serial.sv
// Bit-serial GF(2^8) inverter: y = a^254 over x^8 + g, by square-and-multiply
// built from an LSB-first shift/xtime multiply step, one bit per clock.
module gf_inv_serial (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] g,
    output logic       busy,
    output logic       done,
    output logic [7:0] y
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state_reg, state_next;
    logic [7:0] a_reg, a_next;
    logic [7:0] g_reg, g_next;
    logic [7:0] r_reg, r_next;
    logic [7:0] p_reg, p_next;
    logic [7:0] m_reg, m_next;
    logic [7:0] y_reg, y_next;
    logic [3:0] op_reg, op_next;
    logic [2:0] bit_idx_reg, bit_idx_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;

    logic [7:0] y_operand;
    logic [7:0] p_step;
    logic [7:0] m_step;

    // Exponent 254 = 0b11111110: even ops square R, odd ops multiply R by A.
    assign y_operand = op_reg[0] ? a_reg : r_reg;
    assign p_step    = p_reg ^ (m_reg & {8{y_operand[bit_idx_reg]}});
    assign m_step    = {m_reg[6:0], 1'b0} ^ (g_reg & {8{m_reg[7]}});

    always_comb begin
        state_next   = state_reg;
        a_next       = a_reg;
        g_next       = g_reg;
        r_next       = r_reg;
        p_next       = p_reg;
        m_next       = m_reg;
        y_next       = y_reg;
        op_next      = op_reg;
        bit_idx_next = bit_idx_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next       = a;
                    g_next       = g;
                    r_next       = a;
                    m_next       = a;
                    p_next       = 8'h00;
                    op_next      = 4'd0;
                    bit_idx_next = 3'd0;
                    busy_next    = 1'b1;
                    state_next   = RUN;
                end
            end
            RUN: begin
                bit_idx_next = bit_idx_reg + 3'd1;
                if (bit_idx_reg == 3'd7) begin
                    // Product complete: it becomes R and seeds M for the next op.
                    r_next  = p_step;
                    m_next  = p_step;
                    p_next  = 8'h00;
                    op_next = op_reg + 4'd1;
                    if (op_reg == 4'd12) begin
                        y_next     = p_step;
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                        op_next    = 4'd0;
                        state_next = IDLE;
                    end
                end else begin
                    p_next = p_step;
                    m_next = m_step;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            a_reg       <= 8'h00;
            g_reg       <= 8'h00;
            r_reg       <= 8'h00;
            p_reg       <= 8'h00;
            m_reg       <= 8'h00;
            y_reg       <= 8'h00;
            op_reg      <= 4'd0;
            bit_idx_reg <= 3'd0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            a_reg       <= a_next;
            g_reg       <= g_next;
            r_reg       <= r_next;
            p_reg       <= p_next;
            m_reg       <= m_next;
            y_reg       <= y_next;
            op_reg      <= op_next;
            bit_idx_reg <= bit_idx_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign y    = y_reg;

endmodule

// File: tb/tb_gf_inv_serial.sv
// Directed bench for gf_inv_serial: known inverses, latency, handshake,
// reset behaviour and an exhaustive a*inv(a)==1 sweep in the AES field.
module tb_gf_inv_serial;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] g = 8'h00;
    logic       busy;
    logic       done;
    logic [7:0] y;

    int errors = 0;
    int checks = 0;

    gf_inv_serial dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .g     (g),
        .busy  (busy),
        .done  (done),
        .y     (y)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] w,
                                          input logic [7:0] poly);
        logic [7:0] p = 8'h00;
        logic [7:0] m = x;
        for (int i = 0; i < 8; i++) begin
            if (w[i]) p = p ^ m;
            m = {m[6:0], 1'b0} ^ (m[7] ? poly : 8'h00);
        end
        return p;
    endfunction

    task automatic chk(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Start one transaction and wait (bounded) for done; lat=-1 on timeout.
    task automatic run(input logic [7:0] av, input logic [7:0] gv,
                       output logic [7:0] yv, output int lat);
        @(negedge clk);
        a = av; g = gv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_accept", int'(busy), 1);
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        yv = y;
    endtask

    initial begin
        logic [7:0] yv;
        int lat;
        int ndone;
        int first_done;
        int second_done;

        // Reset from time zero
        #2;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_y", int'(y), 8'h00);
        @(negedge clk); rst_n = 1'b1;

        run(8'h53, 8'h1B, yv, lat);
        chk("aes_53_lat", lat, 104);
        chk("aes_53_y", int'(yv), 8'hCA);
        chk("aes_53_busy_at_done", int'(busy), 0);
        @(posedge clk); #1;
        chk("aes_53_done_pulse", int'(done), 0);
        chk("aes_53_y_hold", int'(y), 8'hCA);
        $display("txn a=53 g=1B y=%02h lat=%0d", yv, lat);

        run(8'h01, 8'h1B, yv, lat);
        chk("aes_01_y", int'(yv), 8'h01);
        $display("txn a=01 g=1B y=%02h lat=%0d", yv, lat);
        run(8'h02, 8'h1B, yv, lat);
        chk("aes_02_y", int'(yv), 8'h8D);
        $display("txn a=02 g=1B y=%02h lat=%0d", yv, lat);
        run(8'h02, 8'h1D, yv, lat);
        chk("f1d_02_y", int'(yv), 8'h8E);
        $display("txn a=02 g=1D y=%02h lat=%0d", yv, lat);
        run(8'h00, 8'h1D, yv, lat);
        chk("zero_lat", lat, 104);
        chk("zero_y", int'(yv), 8'h00);
        $display("txn a=00 g=1D y=%02h lat=%0d", yv, lat);

        // Restarts ignored while busy; inputs changing mid-run have no effect
        @(negedge clk);
        a = 8'h53; g = 8'h1B; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 8'h02; g = 8'h1D;
        ndone = 0; first_done = -1;
        for (int n = 1; n <= 250; n++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (first_done < 0) begin
                    first_done = n;
                    yv = y;
                end
            end
            start = (n == 10 || n == 60);
            if (n == 30) begin a = 8'h07; g = 8'h11; end
        end
        start = 1'b0;
        chk("ignore_ndone", ndone, 1);
        chk("ignore_lat", first_done, 104);
        chk("ignore_y", int'(yv), 8'hCA);
        $display("txn ignore-restart y=%02h dones=%0d", yv, ndone);

        // start held high: done every 105 cycles
        @(negedge clk);
        a = 8'h02; g = 8'h1B; start = 1'b1;
        @(posedge clk); #1;
        ndone = 0; first_done = -1; second_done = -1;
        for (int n = 1; n <= 320; n++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (ndone == 1) first_done = n;
                if (ndone == 2) second_done = n;
                chk("b2b_y", int'(y), 8'h8D);
            end
        end
        start = 1'b0;
        chk("b2b_ndone", ndone, 3);
        chk("b2b_first", first_done, 104);
        chk("b2b_interval", second_done - first_done, 105);
        $display("txn back-to-back dones=%0d first=%0d second=%0d", ndone, first_done, second_done);
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (!busy) begin
                lat = n;
                break;
            end
        end
        chk("b2b_drain", int'(lat > 0), 1);

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        a = 8'h53; g = 8'h1B; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (49) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_y", int'(y), 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        for (int n = 1; n <= 150; n++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("midrst_no_done", ndone, 0);
        $display("txn mid-run reset dones=%0d", ndone);
        run(8'h53, 8'h1B, yv, lat);
        chk("postrst_lat", lat, 104);
        chk("postrst_y", int'(yv), 8'hCA);
        $display("txn post-reset a=53 y=%02h lat=%0d", yv, lat);

        // Every nonzero element of the AES field
        for (int i = 1; i < 256; i++) begin
            run(i[7:0], 8'h1B, yv, lat);
            chk($sformatf("sweep_lat_%02h", i), lat, 104);
            chk($sformatf("sweep_prod_%02h", i), int'(gf_mul(i[7:0], yv, 8'h1B)), 8'h01);
            $display("txn sweep a=%02h y=%02h", i[7:0], yv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
